// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side definitions: protocol byte values, sequencer states
// and a helper that recognises protocol-response bytes.
package ps2_pkg;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] PS2_CMD_SET_LED  = 8'hED;
   localparam logic [7:0] PS2_ACK          = 8'hFA;
   localparam logic [7:0] PS2_BAT_OK       = 8'hAA;
   localparam logic [7:0] PS2_BAT_FAIL     = 8'hFC;
   localparam logic [7:0] PS2_RESEND       = 8'hFE;

   typedef enum logic [3:0] {
      ST_SEND_RST,
      ST_WAIT_ACK_RST,
      ST_WAIT_BAT,
      ST_SEND_RATE_CMD,
      ST_WAIT_ACK1,
      ST_SEND_RATE_VAL,
      ST_WAIT_ACK2,
      ST_READY,
      ST_SEND_LED_CMD,
      ST_WAIT_ACK3,
      ST_SEND_LED_VAL,
      ST_WAIT_ACK4,
      ST_FAIL
   } ps2_state_e;

   // Response bytes the keyboard uses for link control; never scan codes.
   function automatic logic is_proto_byte(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_BAT_FAIL) || (b == PS2_RESEND);
   endfunction

endpackage

// File: rtl/ps2_kbd_host_ctrl_timer.sv
// Loadable response down-counter; expired is high for the single cycle the
// armed count sits at zero, then the timer idles until reloaded.
module ps2_resp_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;
   logic         armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (load) begin
         cnt   <= load_val;
         armed <= 1'b1;
      end else if (armed) begin
         if (cnt == '0) armed <= 1'b0;
         else           cnt   <= cnt - 1'b1;
      end
   end

   assign expired = armed && (cnt == '0);

endmodule

// File: rtl/ps2_kbd_host_ctrl.sv
// PS/2 keyboard host sequencer: reset/BAT/typematic init, LED updates with
// ACK/resend/timeout handling, and filtering of protocol bytes from rx.
module ps2_kbd_host_ctrl
   import ps2_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 2_000_000,
   parameter int         BAT_CYCLES     = 100_000_000,
   parameter int         MAX_RETRY      = 3,
   parameter logic [7:0] TYPEMATIC_VAL  = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_busy,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       rx_pass_valid,
   output logic [7:0] rx_pass_data,
   output logic       init_done,
   output logic       error
);

   localparam int TMAX = (TIMEOUT_CYCLES > BAT_CYCLES) ? TIMEOUT_CYCLES : BAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = $clog2(MAX_RETRY + 2);

   ps2_state_e    state, next_wait, ack_state, retry_state;
   logic [RW-1:0] retry;
   logic          led_pending;
   logic [2:0]    led_latched;
   logic          in_send, issue, is_wait, ack_evt, fail_evt;
   logic          tmr_load, tmr_expired;
   logic [TW-1:0] tmr_val;
   logic [7:0]    send_byte, ack_byte, fail_byte;
   logic          unused_tx_done;

   // Completion is judged only by the keyboard's FA; tx_done carries no ACK meaning.
   assign unused_tx_done = tx_done;

   always_comb begin
      in_send   = 1'b1;
      send_byte = PS2_CMD_RESET;
      next_wait = ST_WAIT_ACK_RST;
      case (state)
         ST_SEND_RST:      ;
         ST_SEND_RATE_CMD: begin send_byte = PS2_CMD_SET_RATE; next_wait = ST_WAIT_ACK1; end
         ST_SEND_RATE_VAL: begin send_byte = TYPEMATIC_VAL;    next_wait = ST_WAIT_ACK2; end
         ST_SEND_LED_CMD:  begin send_byte = PS2_CMD_SET_LED;  next_wait = ST_WAIT_ACK3; end
         // A resend must repeat the byte already on the wire, not a newer LED value.
         ST_SEND_LED_VAL: begin
            send_byte = (retry != '0) ? tx_data : {5'b0, led_latched};
            next_wait = ST_WAIT_ACK4;
         end
         default: in_send = 1'b0;
      endcase
   end

   always_comb begin
      is_wait     = 1'b1;
      ack_byte    = PS2_ACK;
      fail_byte   = PS2_RESEND;
      ack_state   = ST_READY;
      retry_state = ST_SEND_RST;
      case (state)
         ST_WAIT_ACK_RST: ack_state = ST_WAIT_BAT;
         ST_WAIT_BAT: begin
            ack_byte  = PS2_BAT_OK;
            fail_byte = PS2_BAT_FAIL;
            ack_state = ST_SEND_RATE_CMD;
         end
         ST_WAIT_ACK1: begin ack_state = ST_SEND_RATE_VAL; retry_state = ST_SEND_RATE_CMD; end
         ST_WAIT_ACK2: retry_state = ST_SEND_RATE_VAL;
         ST_WAIT_ACK3: begin ack_state = ST_SEND_LED_VAL; retry_state = ST_SEND_LED_CMD; end
         ST_WAIT_ACK4: retry_state = ST_SEND_LED_VAL;
         default: is_wait = 1'b0;
      endcase
   end

   assign issue    = in_send && !tx_busy;
   assign ack_evt  = is_wait && rx_done && (rx_data == ack_byte);
   // A received byte masks a coincident timer expiry.
   assign fail_evt = is_wait && (rx_done ? (rx_data == fail_byte) : tmr_expired);
   assign tmr_load = issue || ((state == ST_WAIT_ACK_RST) && ack_evt);
   assign tmr_val  = issue ? TW'(TIMEOUT_CYCLES) : TW'(BAT_CYCLES);

   assign init_done = (state == ST_READY) || (state == ST_SEND_LED_CMD) || (state == ST_WAIT_ACK3) ||
                      (state == ST_SEND_LED_VAL) || (state == ST_WAIT_ACK4);
   assign error     = (state == ST_FAIL);

   ps2_resp_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_SEND_RST;
         retry         <= '0;
         led_pending   <= 1'b0;
         led_latched   <= 3'b0;
         tx_start      <= 1'b0;
         tx_data       <= 8'h00;
         rx_pass_valid <= 1'b0;
         rx_pass_data  <= 8'h00;
      end else begin
         tx_start <= 1'b0;

         // A fresh request outranks the clear so it is never lost.
         if (led_req && (state != ST_FAIL)) begin
            led_pending <= 1'b1;
            led_latched <= led_val;
         end else if (issue && (state == ST_SEND_LED_VAL) && (retry == '0)) begin
            led_pending <= 1'b0;
         end

         if (issue) begin
            tx_start <= 1'b1;
            tx_data  <= send_byte;
            state    <= next_wait;
         end else if (ack_evt) begin
            state <= ack_state;
            retry <= '0;
         end else if (fail_evt) begin
            if (retry == RW'(MAX_RETRY)) begin
               state <= ST_FAIL;
            end else begin
               retry <= retry + 1'b1;
               state <= retry_state;
            end
         end else if ((state == ST_READY) && led_pending) begin
            state <= ST_SEND_LED_CMD;
         end

         rx_pass_valid <= 1'b0;
         if (rx_done && init_done && !is_proto_byte(rx_data)) begin
            rx_pass_valid <= 1'b1;
            rx_pass_data  <= rx_data;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_host_ctrl.sv
// Directed bench for ps2_kbd_host_ctrl: a transmitter PHY stub, a scripted
// keyboard, and a queue-based model of expected tx bytes and forwarded bytes.
module tb_ps2_kbd_host_ctrl;
   import ps2_pkg::*;

   logic       clk = 1'b0, reset = 1'b1;
   logic       tx_busy = 1'b0, tx_done = 1'b0, rx_done = 1'b0, led_req = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [2:0] led_val = 3'b000;
   logic       tx_start, rx_pass_valid, init_done, error;
   logic [7:0] tx_data, rx_pass_data;

   int         tests = 0, fails = 0, cyc = 0, tx_seen = 0, last_tx_cyc = 0, prev_tx_cyc = 0;
   logic [7:0] exp_tx[$];
   logic [7:0] exp_fwd[$];
   logic [7:0] held_tx = 8'h00;
   logic       prev_start = 1'b0;

   always #5 clk = ~clk;

   ps2_kbd_host_ctrl #(
      .TIMEOUT_CYCLES (50),
      .BAT_CYCLES     (200),
      .MAX_RETRY      (3),
      .TYPEMATIC_VAL  (8'h20)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .rx_done       (rx_done),
      .rx_data       (rx_data),
      .led_req       (led_req),
      .led_val       (led_val),
      .rx_pass_valid (rx_pass_valid),
      .rx_pass_data  (rx_pass_data),
      .init_done     (init_done),
      .error         (error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decoder should see a byte only once initialised and only if it is not link control.
   function automatic bit fwd_model(input bit ready, input logic [7:0] b);
      return ready && !(b inside {8'hFA, 8'hAA, 8'hFE, 8'hFC});
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (tx_start) begin
         chk("tx_start_single_cycle", 32'(prev_start), 0);
         if (exp_tx.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_tx: got %02h, expected no transmission (cycle %0d)", tx_data, cyc);
         end else begin
            chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
         end
         held_tx     = tx_data;
         prev_tx_cyc = last_tx_cyc;
         last_tx_cyc = cyc;
         tx_seen++;
      end else if (tx_busy) begin
         chk("tx_data_held", 32'(tx_data), 32'(held_tx));
      end
      prev_start = tx_start;
      if (rx_pass_valid) begin
         if (exp_fwd.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_fwd: got %02h, expected no forward (cycle %0d)", rx_pass_data, cyc);
         end else begin
            chk("fwd_byte", 32'(rx_pass_data), 32'(exp_fwd.pop_front()));
         end
      end
   end

   // Transmitter PHY stub: busy for five cycles, then a one-cycle done pulse.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (tx_start) begin
            tx_busy = 1'b1;
            repeat (5) @(posedge clk);
            #1; tx_busy = 1'b0; tx_done = 1'b1;
            @(posedge clk); #1; tx_done = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b1; rx_done = 1'b0; led_req = 1'b0;
      tick(3);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_pass_valid", 32'(rx_pass_valid), 0);
      chk("rst_pass_data", 32'(rx_pass_data), 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_retry", 32'(dut.retry), 0);
      chk("rst_led_pending", 32'(dut.led_pending), 0);
      exp_tx.delete(); exp_fwd.delete();
      reset = 1'b0;
   endtask

   task automatic wait_tx(input logic [7:0] b, input int budget);
      int  start;
      bit  got;
      start = tx_seen; got = 0;
      exp_tx.push_back(b);
      for (int i = 0; i < budget && !got; i++) begin
         tick();
         if (tx_seen > start) got = 1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL tx_wait: got no tx_start, expected byte %02h", b);
         exp_tx.delete();
      end else begin
         tick(2);
         for (int i = 0; i < 50 && (tx_busy || tx_done); i++) tick();
      end
   endtask

   task automatic rx_byte(input logic [7:0] b, input bit ready);
      if (fwd_model(ready, b)) exp_fwd.push_back(b);
      rx_data = b; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   // Drives init from the FF ACK onwards (FF already awaited by caller).
   task automatic finish_init();
      rx_byte(8'hFA, 0); tick(3);
      rx_byte(8'hAA, 0);
      wait_tx(8'hF3, 20);
      rx_byte(8'h1C, 0); tick(2);
      rx_byte(8'hFA, 0);
      wait_tx(8'h20, 20);
      chk("init_done_before_last_ack", 32'(init_done), 0);
      rx_byte(8'hFA, 0);
      chk("init_done_after_last_ack", 32'(init_done), 1);
      chk("init_error", 32'(error), 0);
   endtask

   initial begin
      do_reset();
      wait_tx(8'hFF, 20);
      finish_init();

      // LED update with a scan code slipping in ahead of the ED ACK.
      tick(3);
      led_val = 3'b101; led_req = 1'b1; tick(); led_req = 1'b0;
      wait_tx(8'hED, 20);
      chk("led_init_done", 32'(init_done), 1);
      rx_byte(8'h1C, 1);
      chk("led_fwd_valid", 32'(rx_pass_valid), 1);
      chk("led_fwd_data", 32'(rx_pass_data), 32'h1C);
      tick(2);
      rx_byte(8'hFA, 1);
      wait_tx(8'h05, 20);
      rx_byte(8'hFA, 1);
      chk("led_done_ready", 32'(init_done), 1);
      chk("led_pending_cleared", 32'(dut.led_pending), 0);

      // Forwarding in READY.
      tick(2);
      rx_byte(8'h1D, 1); tick();
      rx_byte(8'hF0, 1); tick();
      rx_byte(8'h1D, 1); tick();
      rx_byte(8'hFA, 1); tick(3);
      chk("fwd_all_seen", 32'(exp_fwd.size()), 0);

      // Resend on FE for F3.
      do_reset();
      wait_tx(8'hFF, 20);
      rx_byte(8'hFA, 0); tick(3);
      rx_byte(8'hAA, 0);
      wait_tx(8'hF3, 20);
      rx_byte(8'hFE, 0);
      chk("resend_retry_1", 32'(dut.retry), 1);
      wait_tx(8'hF3, 20);
      rx_byte(8'hFA, 0);
      chk("resend_retry_cleared", 32'(dut.retry), 0);
      wait_tx(8'h20, 20);
      rx_byte(8'hFA, 0);
      chk("resend_init_done", 32'(init_done), 1);

      // BAT failure resends FF.
      do_reset();
      wait_tx(8'hFF, 20);
      rx_byte(8'hFA, 0); tick(3);
      rx_byte(8'hFC, 0);
      wait_tx(8'hFF, 20);
      finish_init();

      // Reset in WAIT_ACK2 restarts with FF.
      do_reset();
      wait_tx(8'hFF, 20);
      rx_byte(8'hFA, 0); tick(3);
      rx_byte(8'hAA, 0);
      wait_tx(8'hF3, 20);
      rx_byte(8'hFA, 0);
      wait_tx(8'h20, 20);
      do_reset();
      wait_tx(8'hFF, 20);
      finish_init();

      // Silent keyboard: four FF attempts about 50 cycles apart, then FAIL.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wait_tx(8'hFF, 80);
         if (k > 0)
            chk("ff_retry_spacing", 32'((last_tx_cyc - prev_tx_cyc >= 45) && (last_tx_cyc - prev_tx_cyc <= 60)), 1);
      end
      chk("fail_tx_count_pre", 32'(error), 0);
      tick(70);
      chk("fail_error", 32'(error), 1);
      chk("fail_init_done", 32'(init_done), 0);
      begin
         int seen;
         seen = tx_seen;
         led_val = 3'b111; led_req = 1'b1; tick(); led_req = 1'b0;
         tick(100);
         chk("fail_led_ignored", 32'(dut.led_pending), 0);
         chk("fail_no_tx", 32'(tx_seen - seen), 0);
         chk("fail_sticky", 32'(error), 1);
      end

      chk("exp_tx_drained", 32'(exp_tx.size()), 0);
      chk("exp_fwd_drained", 32'(exp_fwd.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_host_ctrl.md
Name: ps2_kbd_host_ctrl

Overview:
Host-side sequencer for the PS/2 keyboard link. It drives the PS/2 transmitter through a reset/BAT/typematic-rate initialisation sequence, then services LED-update requests. It also gates the received byte stream, so protocol responses (FA/AA/FE/FC) never reach the scan-code decoder. It sits between the PS/2 rx/tx PHYs and the keyboard scan-code decoder.

Parameters:
TIMEOUT_CYCLES, 2_000_000, cycles allowed from tx_start to the matching ACK (20 ms at 100 MHz)
BAT_CYCLES, 100_000_000, cycles allowed from the reset ACK to the BAT byte (1 s)
MAX_RETRY, 3, retries per command byte before FAIL
TYPEMATIC_VAL, 8'h20, payload sent after F3

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_busy  in  1  transmitter busy; tx_start is only issued when low
tx_done  in  1  one-cycle pulse: byte fully shifted out
tx_start  out  1  one-cycle pulse launching tx_data
tx_data  out  8  byte to transmit; stable from tx_start until tx_done
rx_done  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
led_req  in  1  request LED update (level or pulse, sampled every cycle)
led_val  in  3  {caps, num, scroll}
rx_pass_valid  out  1  forwarded byte strobe to the decoder
rx_pass_data  out  8  forwarded byte
init_done  out  1  high while in READY or an LED-update sequence
error  out  1  high in FAIL

Behaviour:
- Reset values: tx_start=0, tx_data=8'h00, rx_pass_valid=0, rx_pass_data=8'h00, init_done=0, error=0, retry=0, led_pending=0.
- Reset forces state SEND_RST regardless of any activity in flight.
- States and transitions:
  - SEND_RST: wait for tx_busy low, then pulse tx_start with FF and go to WAIT_ACK_RST.
  - WAIT_ACK_RST: FA goes to WAIT_BAT.
  - WAIT_BAT: AA goes to SEND_RATE_CMD. FC, or expiry of BAT_CYCLES, counts as a failure and resends FF.
  - SEND_RATE_CMD: send F3, then WAIT_ACK1.
  - WAIT_ACK1: FA goes to SEND_RATE_VAL.
  - SEND_RATE_VAL: send TYPEMATIC_VAL, then WAIT_ACK2.
  - WAIT_ACK2: FA goes to READY.
  - READY: if led_pending, go to SEND_LED_CMD.
  - SEND_LED_CMD: send ED, then WAIT_ACK3.
  - WAIT_ACK3: FA goes to SEND_LED_VAL.
  - SEND_LED_VAL: send {5'b0, led_latched}, then WAIT_ACK4.
  - WAIT_ACK4: FA goes to READY.
  - FAIL: terminal until reset.
- SEND_* states:
  - Hold until tx_busy=0, then assert tx_start for exactly 1 cycle.
  - tx_data is registered the same cycle and held.
  - The response timer loads TIMEOUT_CYCLES on tx_start.
- WAIT_ACK* rules:
  - FA on rx_done: advance and clear retry.
  - FE: resend the same byte; retry+1.
  - Timer expiry: resend the same byte; retry+1.
  - Any other byte in init waits (WAIT_ACK_RST, WAIT_ACK1/2): dropped, not forwarded.
  - Any other byte in WAIT_ACK3/4: forwarded (a scan code may precede the ACK).
- Retry limit: retry reaching MAX_RETRY on a further failure goes to FAIL, with error=1 and init_done=0.
- Simultaneous events: rx_done in the same cycle as timer expiry gives rx_done priority. A tx_done pulse is not an ACK; the ACK is only rx_data=FA.
- Timer: down-counter, 1 cycle resolution, expiry when it reaches 0. Width = $clog2(max(TIMEOUT_CYCLES, BAT_CYCLES)+1). WAIT_BAT loads BAT_CYCLES on entry.
- Forwarding:
  - In READY, every rx_done byte is forwarded: rx_pass_valid pulses 1 cycle, latency 1 cycle.
  - FA/AA/FE/FC are never forwarded in any state.
- LED requests:
  - led_req=1 in any state except FAIL sets led_pending and latches led_val; the latest value wins (one-deep).
  - led_pending clears when SEND_LED_VAL issues tx_start.
  - A request arriving during an LED sequence is serviced after returning to READY.
  - Before init_done, requests are held pending.
- init_done: 1 in READY, SEND_LED_*, WAIT_ACK3/4; 0 otherwise.

Decomposition:
- Package ps2_pkg holds:
  - Byte constants: PS2_CMD_RESET=FF, PS2_CMD_SET_RATE=F3, PS2_CMD_SET_LED=ED, PS2_ACK=FA, PS2_BAT_OK=AA, PS2_BAT_FAIL=FC, PS2_RESEND=FE.
  - The state enum type.
- Sub-module ps2_resp_timer: loadable down-counter with a load value input and an expired output.

Test Plan:
- Clean init: respond FA then AA to FF, FA to F3, FA to 20 -> tx sequence FF,F3,20; init_done=1 one cycle after the last FA; error=0.
- Resend: answer the first F3 with FE -> F3 retransmitted exactly once; with FA thereafter, init completes; retry back to 0.
- Timeout to FAIL (TIMEOUT_CYCLES=50, MAX_RETRY=3): never answer FF -> 4 FF transmissions spaced about 50 cycles apart, then error=1, init_done=0; later led_req is ignored.
- BAT fail: FA then FC -> FF resent; FA, AA -> init continues normally.
- LED update: in READY, led_req with led_val=3'b101 -> tx ED then 05; a 1C byte arriving before the ED ACK is forwarded on rx_pass_data=1C.
- Forwarding/reset: in READY send 1D,F0,1D -> three rx_pass_valid pulses with the same bytes; FA received in READY -> not forwarded; reset asserted mid-WAIT_ACK2 -> next tx_start carries FF.
